// File: rtl/dispatch_queue_pkg.sv
// Shared RV32I decode constants and the queue entry layout for the dispatch queue.
package dispatch_queue_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   // Word 0 marks a free scoreboard cell, so it can never be a real entry.
   localparam logic [31:0] INSTR_BUBBLE = 32'd0;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } entry_t;

endpackage

// File: rtl/dispatch_queue_if.sv
// Fetch-side and scoreboard-side signals of the dispatch queue.
interface dispatch_queue_if #(parameter int DEPTH = 4);

   logic                         fetch_valid;
   logic [31:0]                  fetch_instr;
   logic [31:0]                  fetch_pc;
   logic                         fetch_ready;
   logic                         disp_valid;
   logic                         disp_accept;
   logic [31:0]                  instr_out;
   logic [31:0]                  pc_out;
   logic [4:0]                   rs1_out;
   logic [4:0]                   rs2_out;
   logic [4:0]                   rd_out;
   logic [$clog2(DEPTH+1)-1:0]   count;

   modport slave (
      input  fetch_valid, fetch_instr, fetch_pc, disp_accept,
      output fetch_ready, disp_valid, instr_out, pc_out, rs1_out, rs2_out, rd_out, count
   );

   modport master (
      output fetch_valid, fetch_instr, fetch_pc, disp_accept,
      input  fetch_ready, disp_valid, instr_out, pc_out, rs1_out, rs2_out, rd_out, count
   );

endinterface

// File: rtl/dispatch_queue_rv32_reg_decode.sv
// Combinational RV32I register-field extraction; unused fields report x0 (no dependency).
module rv32_reg_decode
   import dispatch_queue_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd
);

   logic [4:0] w_rs1_f;
   logic [4:0] w_rs2_f;
   logic [4:0] w_rd_f;

   assign w_rs1_f = i_instr[RS1_LSB +: 5];
   assign w_rs2_f = i_instr[RS2_LSB +: 5];
   assign w_rd_f  = i_instr[RD_LSB +: 5];

   always_comb begin
      o_rs1 = 5'd0;
      o_rs2 = 5'd0;
      o_rd  = 5'd0;
      case (i_instr[6:0])
         OPC_OP: begin
            o_rs1 = w_rs1_f;
            o_rs2 = w_rs2_f;
            o_rd  = w_rd_f;
         end
         OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
            o_rs1 = w_rs1_f;
            o_rd  = w_rd_f;
         end
         OPC_STORE, OPC_BRANCH: begin
            o_rs1 = w_rs1_f;
            o_rs2 = w_rs2_f;
         end
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            o_rd  = w_rd_f;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer between fetch and the scoreboard; decodes register
// fields at enqueue and presents the oldest entry straight from storage.
module dispatch_queue
   import dispatch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset_sync,
   input  logic              flush,
   dispatch_queue_if.slave   bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C   = CW'(1);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_head;
   logic [PW-1:0]   r_tail;
   logic [CW-1:0]   r_count;

   logic            w_ready;
   logic            w_valid;
   logic            w_enq;
   logic            w_deq;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   entry_t          w_new;

   rv32_reg_decode u_decode (
      .i_instr (bus.fetch_instr),
      .o_rs1   (w_rs1),
      .o_rs2   (w_rs2),
      .o_rd    (w_rd)
   );

   // Ready depends only on registered occupancy; a slot freed this cycle is offered next cycle.
   assign w_ready = (r_count < DEPTH_C);
   assign w_valid = (r_count != '0);
   assign w_enq   = bus.fetch_valid & w_ready & (bus.fetch_instr != INSTR_BUBBLE);
   assign w_deq   = w_valid & bus.disp_accept;

   always_comb begin
      w_new       = '0;
      w_new.instr = bus.fetch_instr;
      w_new.pc    = bus.fetch_pc;
      w_new.rs1   = w_rs1;
      w_new.rs2   = w_rs2;
      w_new.rd    = w_rd;
   end

   always_ff @(posedge clock) begin
      if (reset_sync || flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_tail <= r_tail + ONE_P;
         if (w_deq) r_head <= r_head + ONE_P;
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + ONE_C;
            2'b01:   r_count <= r_count - ONE_C;
            default: r_count <= r_count;
         endcase
      end
   end

   // Dequeued slots are cleared so the head entry reads as zero whenever the queue is empty.
   // Enqueue and dequeue never hit the same slot: a full queue refuses enqueue.
   always_ff @(posedge clock) begin
      if (reset_sync || flush) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_deq) r_mem[r_head] <= '0;
         if (w_enq) r_mem[r_tail] <= w_new;
      end
   end

   assign bus.fetch_ready = w_ready;
   assign bus.disp_valid  = w_valid;
   assign bus.instr_out   = r_mem[r_head].instr;
   assign bus.pc_out      = r_mem[r_head].pc;
   assign bus.rs1_out     = r_mem[r_head].rs1;
   assign bus.rs2_out     = r_mem[r_head].rs2;
   assign bus.rd_out      = r_mem[r_head].rd;
   assign bus.count       = r_count;

endmodule
